fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the write port of one async_fifo among NUM_REQ requesters in the write_clk domain.
//  Round-robin arbitration with packet/burst lock: a grant is held until the requester's last
//  word or MAX_BURST words, whichever comes first. Drives p_write_en/p_write_data and honours
//  p_write_full so the FIFO is never written when full.
// PARAMETERS
//  BITS       32  width of each data word; matches async_fifo BITS
//  NUM_REQ    4   number of requesters, >=2
//  MAX_BURST  8   max words per grant before forced re-arbitration, >=1
// PORTS
//  write_clk     in   1             write-domain clock
//  write_rst_n   in   1             asynchronous active-low reset
//  req_valid     in   NUM_REQ       requester i has a word on req_data[i]
//  req_data      in   NUM_REQ*BITS  word of requester i at [i*BITS +: BITS]
//  req_last      in   NUM_REQ       word of requester i is the last of its packet
//  req_ready     out  NUM_REQ       word of requester i accepted this cycle when valid&ready
//  grant         out  NUM_REQ       one-hot current owner; 0 when idle
//  busy          out  1             arbiter in BURST state
//  p_write_en    out  1             to async_fifo: write request
//  p_write_data  out  BITS          to async_fifo: write data
//  p_write_full  in   1             from async_fifo: full flag
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, grant=0, busy=0, burst_cnt=0,
//    last_grant=NUM_REQ-1 so requester 0 wins first. req_ready=0, p_write_en=0, p_write_data=0.
//  - States:
//    IDLE: if any req_valid, pick the first set bit scanning last_grant+1 .. last_grant
//      (modulo NUM_REQ). Register grant/last_grant. Go to BURST. One cycle arbitration latency.
//      No transfer occurs in IDLE.
//    BURST: owner g.
//      req_ready[g] = !p_write_full. All other req_ready bits = 0.
//      xfer = req_valid[g] & req_ready[g].
//      p_write_en = xfer, combinational. p_write_data = req_data[g] when xfer, else 0.
//      On xfer: burst_cnt++.
//      On xfer & (req_last[g] | burst_cnt==MAX_BURST-1): burst_cnt=0, grant=0, go to IDLE.
//  - p_write_full=1: stall. No xfer, burst_cnt holds, grant held indefinitely. p_write_en is
//    never 1 while p_write_full=1.
//  - Owner drops req_valid mid-burst: grant held (packet lock), no timeout, no count.
//  - MAX_BURST cut: the packet continues at the requester's next grant. last_grant=g, so other
//    valid requesters are served first.
//  - Simultaneous requests in IDLE: round-robin order only. Valid bits arriving during BURST
//    wait for IDLE.
//  - Fairness: a requester holding valid continuously is granted within NUM_REQ-1 other grants.
//  - burst_cnt width is $clog2(MAX_BURST+1). It does not wrap because it clears at
//    MAX_BURST-1.
//  - Reset mid-burst drops the grant immediately. A word not yet accepted is not written.
//  - Requester contract: req_data/req_last stable while valid&!ready. Not checked in RTL.
// STRUCTURE
//  - Package fifo_arb_pkg: typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t; arbitration
//    helper functions shared with bench scoreboard.
//  - Sub-module rr_arbiter #(N): combinational round-robin pick (req, last_grant -> one-hot
//    grant, any). Reused by future read-side schedulers.
//  - Top: state register, grant/last_grant/burst_cnt registers, output mux.
// TESTING  (BITS=32, NUM_REQ=4, MAX_BURST=4, bench clocks as async_fifo bench)
//  1 reset: write_rst_n=0 mid-burst -> grant=0, busy=0, p_write_en=0 same time step;
//    after release, req0 wins first.
//  2 single: req1 sends 3 words 0xA0..0xA2, last on 0xA2 -> grant=4'b0010 after 1 cycle;
//    3 back-to-back p_write_en; FIFO read returns A0,A1,A2; then IDLE.
//  3 round-robin: all 4 valid, 1-word packets -> grant order 0,1,2,3,0; FIFO data order
//    matches; no requester granted twice before the others.
//  4 burst cut: req2 sends 6-word packet with req3 valid -> 4 words from req2, then req3's
//    packet, then req2's remaining 2 words.
//  5 full: 20 words from req0, read side stalled -> exactly SIZE=16 writes accepted;
//    p_write_en=0 whenever p_write_full=1. Release reads -> remaining 4 words arrive in order.
//  6 owner gap: req0 drops valid 3 cycles mid-packet while req1 valid -> grant stays
//    4'b0001; req1 served only after req0's last.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the write-side FIFO arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // (base + off) mod n for base < n and 1 <= off <= n; avoids a divider in the picker.
  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after last_i, wrapping; zero latency.
// No backpressure of its own; any_o is low and gnt_o zero when nothing requests.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = last_i;
    any_o     = 1'b0;
    cand      = '0;
    // Scan last_i+1 .. last_i so the previous owner is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = IW'(rr_wrap(32'(last_i), k, N));
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin share of one async_fifo write port with packet lock, capped at MAX_BURST words.
// One idle cycle to arbitrate, then one word per cycle; p_write_full stalls the owner, never drops.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                    write_clk,
  input  logic                    write_rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    p_write_en,
  output logic [BITS-1:0]         p_write_data,
  input  logic                    p_write_full
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDX_INIT = IW'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [BITS-1:0]    own_data;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic               burst_end;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i     (req_valid),
    .last_i    (last_q),
    .gnt_o     (pick),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // grant_q is one-hot in BURST and zero in IDLE, so it doubles as the owner select.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_data  = req_data[i*BITS +: BITS];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  assign xfer      = (state_q == ARB_BURST) && own_valid && !p_write_full;
  assign burst_end = xfer && (own_last || (cnt_q == CNT_LAST));

  assign req_ready    = p_write_full ? '0 : grant_q;
  assign grant        = grant_q;
  assign busy         = (state_q == ARB_BURST);
  assign p_write_en   = xfer;
  assign p_write_data = xfer ? own_data : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BURST;
          grant_d = pick;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        // A cut burst leaves last_q at the owner, so everyone else goes first next time.
        if (burst_end) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_write_when_full: assert property (@(posedge write_clk) disable iff (!write_rst_n)
    !(p_write_en && p_write_full));

  a_grant_onehot0: assert property (@(posedge write_clk) disable iff (!write_rst_n)
    $onehot0(grant_q));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a 16-entry FIFO model on the write port.
module tb_fifo_write_arbiter;

  localparam int BITS = 32;
  localparam int NR   = 4;
  localparam int MB   = 4;
  localparam int SIZE = 16;

  logic              write_clk;
  logic              write_rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*BITS-1:0] req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              p_write_en;
  logic [BITS-1:0]   p_write_data;
  logic              p_write_full;

  fifo_write_arbiter #(.BITS(BITS), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .write_clk    (write_clk),
    .write_rst_n  (write_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .p_write_en   (p_write_en),
    .p_write_data (p_write_data),
    .p_write_full (p_write_full)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        full;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rdy;
    logic        e_wen;
    logic [31:0] e_dat;
    logic        e_busy;
  } vec_t;

  vec_t tv[13];

  // ---------------- requester / FIFO model ----------------
  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t       rq[NR][$];
  logic [31:0] fq[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_d[$];
  int          gq[$];
  int          exp_g[$];
  int          gap[NR];
  bit          rd_en;
  logic [3:0]  s_grant;
  logic        s_wen;
  logic        s_busy;
  logic [3:0]  seen_grant;
  int          wen_full_err, wen_cnt, cyc, first_wen, last_wen;

  task automatic push(input int i, input logic [31:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    rq[i].push_back(w);
  endtask

  task automatic clr();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      gap[i] = 0;
    end
    fq.delete();
    out_q.delete();
    exp_d.delete();
    gq.delete();
    exp_g.delete();
    seen_grant   = '0;
    wen_full_err = 0;
    wen_cnt      = 0;
    cyc          = 0;
    first_wen    = -1;
    last_wen     = -1;
    rd_en        = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && gap[i] == 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*BITS +: BITS] = rq[i][0].d;
        req_last[i]            = rq[i][0].l;
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*BITS +: BITS] = '0;
        req_last[i]            = 1'b0;
      end
    end
    p_write_full = (fq.size() >= SIZE);
  endtask

  task automatic cycle();
    drive();
    @(negedge write_clk);
    s_grant = grant;
    s_wen   = p_write_en;
    s_busy  = busy;
    if (p_write_en && p_write_full) wen_full_err++;
    if (p_write_en) begin
      wen_cnt++;
      if (first_wen < 0) first_wen = cyc;
      last_wen = cyc;
      fq.push_back(p_write_data);
    end
    if (grant != 0 && seen_grant == 0) begin
      for (int i = 0; i < NR; i++) if (grant[i]) gq.push_back(i);
    end
    seen_grant = grant;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    end
    if (rd_en && fq.size() > 0) out_q.push_back(fq.pop_front());
    cyc++;
    @(posedge write_clk);
    #1;
    for (int i = 0; i < NR; i++) if (gap[i] > 0) gap[i]--;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic chk_data(input string nm);
    logic [31:0] a;
    chk({nm, " count"}, out_q.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      a = (i < out_q.size()) ? out_q[i] : 32'hxxxxxxxx;
      chk($sformatf("%s word%0d", nm, i), a, exp_d[i]);
    end
  endtask

  task automatic chk_grants(input string nm);
    logic [31:0] a;
    chk({nm, " grants"}, gq.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++) begin
      a = (i < gq.size()) ? gq[i] : 32'hxxxxxxxx;
      chk($sformatf("%s grant%0d", nm, i), a, exp_g[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid, last, full | grant, ready, wen, data, busy  (data word of req i is D0+i)
    tv[0]  = '{4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};
    tv[1]  = '{4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 1'b1, 32'hD0, 1'b1};
    tv[2]  = '{4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};
    tv[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 4'h0, 1'b0, 32'h00, 1'b1};
    tv[4]  = '{4'hF, 4'hF, 1'b0, 4'h2, 4'h2, 1'b1, 32'hD1, 1'b1};
    tv[5]  = '{4'h5, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};
    tv[6]  = '{4'h5, 4'h0, 1'b0, 4'h4, 4'h4, 1'b1, 32'hD2, 1'b1};
    tv[7]  = '{4'h1, 4'h0, 1'b0, 4'h4, 4'h4, 1'b0, 32'h00, 1'b1};
    tv[8]  = '{4'h5, 4'h4, 1'b0, 4'h4, 4'h4, 1'b1, 32'hD2, 1'b1};
    tv[9]  = '{4'h9, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};
    tv[10] = '{4'h9, 4'hF, 1'b0, 4'h8, 4'h8, 1'b1, 32'hD3, 1'b1};
    tv[11] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};
    tv[12] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h00, 1'b0};

    clr();
    write_rst_n  = 1'b0;
    req_valid    = 4'hF;
    req_last     = 4'hF;
    req_data     = '0;
    p_write_full = 1'b0;
    #3;
    chk("reset grant", grant, 4'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset wen", p_write_en, 1'b0);
    chk("reset ready", req_ready, 4'h0);
    chk("reset data", p_write_data, 32'h0);
    @(posedge write_clk);
    #1;
    write_rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      req_valid    = tv[v].vld;
      req_last     = tv[v].lst;
      p_write_full = tv[v].full;
      for (int i = 0; i < NR; i++) req_data[i*BITS +: BITS] = 32'hD0 + 32'(i);
      @(negedge write_clk);
      chk($sformatf("v%0d grant", v), grant, tv[v].e_gnt);
      chk($sformatf("v%0d ready", v), req_ready, tv[v].e_rdy);
      chk($sformatf("v%0d wen", v), p_write_en, tv[v].e_wen);
      chk($sformatf("v%0d data", v), p_write_data, tv[v].e_dat);
      chk($sformatf("v%0d busy", v), busy, tv[v].e_busy);
      @(posedge write_clk);
      #1;
    end

    // reset mid-burst of req2: grant dropped at once, req0 first again after release
    clr();
    push(2, 32'hE20, 1'b0);
    push(2, 32'hE21, 1'b0);
    push(2, 32'hE22, 1'b0);
    run(2);
    chk("rst pre busy", s_busy, 1'b1);
    chk("rst pre grant", s_grant, 4'b0100);
    drive();
    write_rst_n = 1'b0;
    #1;
    chk("rst mid grant", grant, 4'h0);
    chk("rst mid busy", busy, 1'b0);
    chk("rst mid wen", p_write_en, 1'b0);
    chk("rst mid ready", req_ready, 4'h0);
    @(posedge write_clk);
    #1;
    write_rst_n = 1'b1;
    clr();
    push(3, 32'hE30, 1'b1);
    push(0, 32'hE00, 1'b1);
    run(8);
    exp_g = {0, 3};
    exp_d = {32'hE00, 32'hE30};
    chk_grants("rst");
    chk_data("rst");

    // round-robin over all four, req0 coming back last
    clr();
    for (int i = 0; i < NR; i++) push(i, 32'hB0 + 32'(i), 1'b1);
    push(0, 32'hB4, 1'b1);
    run(14);
    exp_g = {0, 1, 2, 3, 0};
    exp_d = {32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    chk_grants("rr");
    chk_data("rr");

    // single 3-word packet from req1
    clr();
    push(1, 32'hA0, 1'b0);
    push(1, 32'hA1, 1'b0);
    push(1, 32'hA2, 1'b1);
    cycle();
    chk("single arb grant", s_grant, 4'h0);
    cycle();
    chk("single grant", s_grant, 4'b0010);
    chk("single first wen", s_wen, 1'b1);
    run(6);
    chk("single wen count", wen_cnt, 3);
    chk("single back2back", last_wen - first_wen, 2);
    chk("single idle", s_busy, 1'b0);
    exp_d = {32'hA0, 32'hA1, 32'hA2};
    chk_data("single");

    // burst cut: req2 6 words vs req3 2 words
    clr();
    for (int k = 0; k < 6; k++) push(2, 32'hC0 + 32'(k), (k == 5));
    push(3, 32'hD0, 1'b0);
    push(3, 32'hD1, 1'b1);
    run(16);
    exp_g = {2, 3, 2};
    exp_d = {32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1, 32'hC4, 32'hC5};
    chk_grants("cut");
    chk_data("cut");

    // FIFO full: 20 words from req0 with reads stalled
    clr();
    rd_en = 1'b0;
    for (int k = 0; k < 20; k++) push(0, 32'h5000 + 32'(k), (k == 19));
    run(60);
    chk("full writes", wen_cnt, SIZE);
    chk("full fifo level", fq.size(), SIZE);
    chk("full grant held", s_grant, 4'b0001);
    chk("full busy held", s_busy, 1'b1);
    rd_en = 1'b1;
    run(40);
    chk("full total writes", wen_cnt, 20);
    chk("full wen while full", wen_full_err, 0);
    for (int k = 0; k < 20; k++) exp_d.push_back(32'h5000 + 32'(k));
    chk_data("full");

    // owner gap: req0 drops valid 3 cycles while req1 waits
    clr();
    for (int k = 0; k < 4; k++) push(0, 32'hE0 + 32'(k), (k == 3));
    cycle();
    push(1, 32'hF0, 1'b1);
    cycle();
    chk("gap first wen", s_wen, 1'b1);
    gap[0] = 3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("gap%0d grant", k), s_grant, 4'b0001);
      chk($sformatf("gap%0d wen", k), s_wen, 1'b0);
    end
    run(12);
    exp_g = {0, 1};
    exp_d = {32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hF0};
    chk_grants("gap");
    chk_data("gap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
